// File: rtl/udm_pkg.sv
// Shared definitions for the udm two-master bus arbiter: FSM state
// encoding, arbitration mode selectors, one-hot grant codes and the
// read data returned on a watchdog-forced completion.
package udm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/udm_rr_grant.sv
// Combinational winner select for two masters. Produces a one-hot grant
// {m1,m0} from the request vector, the previous owner and the mode
// (0 = round-robin, 1 = fixed priority with m0 winning ties).
module udm_rr_grant
    import udm_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic [1:0] i_last_grant,
    input  logic       i_mode,
    output logic [1:0] o_grant
);

    // Single requester wins; a tie goes to m0 in fixed mode, otherwise to
    // whichever master did not own the bus last.
    always_comb begin
        o_grant = GRANT_NONE;
        case (i_req)
            2'b01:   o_grant = GRANT_M0;
            2'b10:   o_grant = GRANT_M1;
            2'b11: begin
                if (i_mode) begin
                    o_grant = GRANT_M0;
                end else begin
                    o_grant = (i_last_grant == GRANT_M0) ? GRANT_M1 : GRANT_M0;
                end
            end
            default: o_grant = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/udm_bus_arbiter.sv
// Two-master (udm host m0, system core m1) to one-slave arbiter on the
// udm enb/we/addr/wdata/ack/rdata bus. All outputs are registered; a
// transaction runs IDLE -> BUSY -> RESP, giving a minimum 3-cycle spacing.
// Optional feature: define UDM_ARB_TIMEOUT_EN to enable the slave-ack
// watchdog (TIMEOUT_CYC cycles, sticky err_o, DEADBEEF read data).
module udm_bus_arbiter
    import udm_pkg::*;
#(
    parameter int unsigned ARB_MODE    = ARB_RR,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk_i,
    input  logic        reset_ni,

    input  logic        m0_enb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [31:0] m0_wdata_bi,
    output logic        m0_ack_o,
    output logic [31:0] m0_rdata_bo,

    input  logic        m1_enb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m1_ack_o,
    output logic [31:0] m1_rdata_bo,

    output logic        slv_enb_o,
    output logic        slv_we_o,
    output logic [31:0] slv_addr_bo,
    output logic [31:0] slv_wdata_bo,
    input  logic        slv_ack_i,
    input  logic [31:0] slv_rdata_bi,

    output logic [1:0]  grant_bo,
    output logic        err_o
);

    arb_state_t  r_state;
    logic [1:0]  r_last_grant;
    logic [1:0]  r_grant;
    logic        r_slv_enb;
    logic        r_slv_we;
    logic [31:0] r_slv_addr;
    logic [31:0] r_slv_wdata;
    logic        r_m0_ack;
    logic        r_m1_ack;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic [1:0]  w_grant;
    logic        w_complete;
    logic        w_timeout;
    logic [31:0] w_cpl_rdata;

    udm_rr_grant u_grant (
        .i_req        ({m1_enb_i, m0_enb_i}),
        .i_last_grant (r_last_grant),
        .i_mode       (ARB_MODE == ARB_FIXED),
        .o_grant      (w_grant)
    );

`ifdef UDM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_wd_cnt;
    logic        r_err;

    // Watchdog: zero outside BUSY, counts BUSY cycles without a slave ack;
    // the error flag stays set until reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != ST_BUSY) begin
                r_wd_cnt <= '0;
            end else if (!slv_ack_i) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    // Completion decode for BUSY: a real slave ack always beats the watchdog.
    always_comb begin
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_cpl_rdata = slv_rdata_bi;
        if (r_state == ST_BUSY) begin
            if (slv_ack_i) begin
                w_complete = 1'b1;
            end
`ifdef UDM_ARB_TIMEOUT_EN
            else if (r_wd_cnt == TO_LAST) begin
                w_complete  = 1'b1;
                w_timeout   = 1'b1;
                w_cpl_rdata = ERR_RDATA;
            end
`endif
        end
    end

    // Arbitration FSM with registered slave-side and master-side outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_M1;
            r_grant      <= GRANT_NONE;
            r_slv_enb    <= 1'b0;
            r_slv_we     <= 1'b0;
            r_slv_addr   <= '0;
            r_slv_wdata  <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != GRANT_NONE) begin
                        r_grant   <= w_grant;
                        r_slv_enb <= 1'b1;
                        if (w_grant == GRANT_M1) begin
                            r_slv_we    <= m1_we_i;
                            r_slv_addr  <= m1_addr_bi;
                            r_slv_wdata <= m1_wdata_bi;
                        end else begin
                            r_slv_we    <= m0_we_i;
                            r_slv_addr  <= m0_addr_bi;
                            r_slv_wdata <= m0_wdata_bi;
                        end
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_complete) begin
                        r_slv_enb   <= 1'b0;
                        r_slv_we    <= 1'b0;
                        r_slv_wdata <= '0;
                        if (r_grant == GRANT_M1) begin
                            r_m1_ack   <= 1'b1;
                            r_m1_rdata <= w_cpl_rdata;
                        end else begin
                            r_m0_ack   <= 1'b1;
                            r_m0_rdata <= w_cpl_rdata;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_m0_ack     <= 1'b0;
                    r_m1_ack     <= 1'b0;
                    r_grant      <= GRANT_NONE;
                    r_last_grant <= r_grant;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign slv_enb_o    = r_slv_enb;
    assign slv_we_o     = r_slv_we;
    assign slv_addr_bo  = r_slv_addr;
    assign slv_wdata_bo = r_slv_wdata;
    assign m0_ack_o     = r_m0_ack;
    assign m0_rdata_bo  = r_m0_rdata;
    assign m1_ack_o     = r_m1_ack;
    assign m1_rdata_bo  = r_m1_rdata;
    assign grant_bo     = r_grant;

endmodule

// File: tb/tb_udm_bus_arbiter.sv
// Bench for udm_bus_arbiter: instance 0 is round-robin, instance 1 fixed
// priority. Queue-driven masters, a delay-programmable slave, a
// transaction-level reference model compared every cycle, plus directed
// literal checks on grant order, data and latency.
module tb_udm_bus_arbiter;

    localparam int TO_CYC = 8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [1:0]  grant;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } slog_t;

    logic clk;
    logic rst_n;
    int   cyc;

    logic [1:0]  m_enb   [2];
    logic [1:0]  m_we    [2];
    logic [31:0] m_addr  [2][2];
    logic [31:0] m_wdata [2][2];
    logic [1:0]  m_ack   [2];
    logic [31:0] m_rdata [2][2];
    logic        s_enb   [2];
    logic        s_we    [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic        s_ack   [2];
    logic [31:0] s_rdata [2];
    logic [1:0]  grant   [2];
    logic        err     [2];

    int checks;
    int failures;

    txn_t  mq [4][$];
    int    s_delay [2];
    int    s_cnt   [2];
    logic  s_prev  [2];
    slog_t slv_log [2][$];
    int    ack_who [2][$];
    int    ack_cyc [2][$];
    logic [31:0] ack_dat [2][$];

    // reference model state
    int          md_stage [2];
    int          md_owner [2];
    int          md_last  [2];
    int          md_wait  [2];
    logic [1:0]  e_grant  [2];
    logic        e_senb   [2];
    logic        e_swe    [2];
    logic [31:0] e_saddr  [2];
    logic [31:0] e_swdata [2];
    logic [1:0]  e_ack    [2];
    logic [31:0] e_rdata  [2][2];
    logic        e_err    [2];

    udm_bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYC(TO_CYC)) u_rr (
        .clk_i(clk), .reset_ni(rst_n),
        .m0_enb_i(m_enb[0][0]), .m0_we_i(m_we[0][0]), .m0_addr_bi(m_addr[0][0]),
        .m0_wdata_bi(m_wdata[0][0]), .m0_ack_o(m_ack[0][0]), .m0_rdata_bo(m_rdata[0][0]),
        .m1_enb_i(m_enb[0][1]), .m1_we_i(m_we[0][1]), .m1_addr_bi(m_addr[0][1]),
        .m1_wdata_bi(m_wdata[0][1]), .m1_ack_o(m_ack[0][1]), .m1_rdata_bo(m_rdata[0][1]),
        .slv_enb_o(s_enb[0]), .slv_we_o(s_we[0]), .slv_addr_bo(s_addr[0]),
        .slv_wdata_bo(s_wdata[0]), .slv_ack_i(s_ack[0]), .slv_rdata_bi(s_rdata[0]),
        .grant_bo(grant[0]), .err_o(err[0])
    );

    udm_bus_arbiter #(.ARB_MODE(1), .TIMEOUT_CYC(TO_CYC)) u_fx (
        .clk_i(clk), .reset_ni(rst_n),
        .m0_enb_i(m_enb[1][0]), .m0_we_i(m_we[1][0]), .m0_addr_bi(m_addr[1][0]),
        .m0_wdata_bi(m_wdata[1][0]), .m0_ack_o(m_ack[1][0]), .m0_rdata_bo(m_rdata[1][0]),
        .m1_enb_i(m_enb[1][1]), .m1_we_i(m_we[1][1]), .m1_addr_bi(m_addr[1][1]),
        .m1_wdata_bi(m_wdata[1][1]), .m1_ack_o(m_ack[1][1]), .m1_rdata_bo(m_rdata[1][1]),
        .slv_enb_o(s_enb[1]), .slv_we_o(s_we[1]), .slv_addr_bo(s_addr[1]),
        .slv_wdata_bo(s_wdata[1]), .slv_ack_i(s_ack[1]), .slv_rdata_bi(s_rdata[1]),
        .grant_bo(grant[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner by the arbitration rules; instance 1 is fixed priority.
    function automatic int pick(input int i);
        if (m_enb[i] == 2'b01) return 0;
        if (m_enb[i] == 2'b10) return 1;
        if (i == 1) return 0;
        return (md_last[i] == 0) ? 1 : 0;
    endfunction

    // Master agents: present the head of each queue, retire it on ack.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (m_ack[k/2][k%2] && mq[k].size() > 0) void'(mq[k].pop_front());
            if (mq[k].size() > 0) begin
                m_enb[k/2][k%2]   = 1'b1;
                m_we[k/2][k%2]    = mq[k][0].we;
                m_addr[k/2][k%2]  = mq[k][0].addr;
                m_wdata[k/2][k%2] = mq[k][0].wdata;
            end else begin
                m_enb[k/2][k%2] = 1'b0;
                m_we[k/2][k%2]  = 1'b0;
            end
        end
    end

    // Slave agents: ack s_delay cycles after the request appears.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (s_ack[i]) begin
                s_ack[i] = 1'b0;
                s_cnt[i] = 0;
            end else if (!s_enb[i]) begin
                s_cnt[i] = 0;
            end else if (s_cnt[i] == s_delay[i]) begin
                s_ack[i]   = 1'b1;
                s_rdata[i] = s_addr[i] ^ 32'h1234_5678;
            end else begin
                s_cnt[i] = s_cnt[i] + 1;
            end
        end
    end

    // Reference model, advanced on every clock edge from the bus inputs.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                md_stage[i] <= 0; md_owner[i] <= 0; md_last[i] <= 1; md_wait[i] <= 0;
                e_grant[i] <= 2'b00; e_senb[i] <= 1'b0; e_swe[i] <= 1'b0;
                e_saddr[i] <= '0; e_swdata[i] <= '0; e_ack[i] <= 2'b00;
                e_rdata[i][0] <= '0; e_rdata[i][1] <= '0; e_err[i] <= 1'b0;
            end else if (md_stage[i] == 0) begin
                if (m_enb[i] != 2'b00) begin
                    md_owner[i] <= pick(i);
                    md_stage[i] <= 1;
                    md_wait[i]  <= 0;
                    e_grant[i]  <= (pick(i) == 1) ? 2'b10 : 2'b01;
                    e_senb[i]   <= 1'b1;
                    e_swe[i]    <= m_we[i][pick(i)];
                    e_saddr[i]  <= m_addr[i][pick(i)];
                    e_swdata[i] <= m_wdata[i][pick(i)];
                end
            end else if (md_stage[i] == 1) begin
                if (s_ack[i]) begin
                    md_stage[i] <= 2;
                    e_senb[i] <= 1'b0; e_swe[i] <= 1'b0; e_swdata[i] <= '0;
                    e_ack[i][md_owner[i]]   <= 1'b1;
                    e_rdata[i][md_owner[i]] <= s_rdata[i];
                end
`ifdef UDM_ARB_TIMEOUT_EN
                else if (md_wait[i] + 1 == TO_CYC) begin
                    md_stage[i] <= 2;
                    e_senb[i] <= 1'b0; e_swe[i] <= 1'b0; e_swdata[i] <= '0;
                    e_ack[i][md_owner[i]]   <= 1'b1;
                    e_rdata[i][md_owner[i]] <= 32'hDEAD_BEEF;
                    e_err[i] <= 1'b1;
                end
`endif
                else begin
                    md_wait[i] <= md_wait[i] + 1;
                end
            end else begin
                md_stage[i] <= 0;
                md_last[i]  <= md_owner[i];
                e_ack[i]    <= 2'b00;
                e_grant[i]  <= 2'b00;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model, plus logs.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("cycle_inst%0d", i),
                  {grant[i], s_enb[i], s_we[i], s_addr[i], s_wdata[i], m_ack[i],
                   m_rdata[i][1], m_rdata[i][0], err[i]},
                  {e_grant[i], e_senb[i], e_swe[i], e_saddr[i], e_swdata[i], e_ack[i],
                   e_rdata[i][1], e_rdata[i][0], e_err[i]});
            if (s_enb[i] && !s_prev[i])
                slv_log[i].push_back('{grant[i], s_we[i], s_addr[i], s_wdata[i], cyc});
            s_prev[i] = s_enb[i];
            for (int j = 0; j < 2; j++) begin
                if (m_ack[i][j]) begin
                    ack_who[i].push_back(j);
                    ack_cyc[i].push_back(cyc);
                    ack_dat[i].push_back(m_rdata[i][j]);
                end
            end
        end
    end

    task automatic push(input int i, input int j, input logic we, input logic [31:0] a, input logic [31:0] d);
        mq[2*i+j].push_back('{we, a, d});
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            slv_log[i].delete(); ack_who[i].delete(); ack_cyc[i].delete(); ack_dat[i].delete();
        end
    endtask

    task automatic quiet(input int i);
        int n;
        for (n = 0; n < 400; n++) begin
            @(posedge clk); #2;
            if (mq[2*i].size() == 0 && mq[2*i+1].size() == 0 && md_stage[i] == 0) break;
        end
        check("quiet_bound", (n < 400), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_order(input string name, input int i, input int exp_who[4], input int n);
        check({name, "_count"}, ack_who[i].size(), n);
        for (int k = 0; k < n && k < ack_who[i].size(); k++)
            check($sformatf("%s_%0d", name, k), ack_who[i][k], exp_who[k]);
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            m_enb[i] = 2'b00; m_we[i] = 2'b00;
            for (int j = 0; j < 2; j++) begin m_addr[i][j] = '0; m_wdata[i][j] = '0; end
            s_ack[i] = 1'b0; s_rdata[i] = '0; s_cnt[i] = 0; s_delay[i] = 2; s_prev[i] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_slv_enb", {s_enb[0], s_enb[1]}, 2'b00);
        check("reset_grant", {grant[0], grant[1]}, 4'b0000);
        check("reset_ack", {m_ack[0], m_ack[1]}, 4'b0000);
        check("reset_rdata", m_rdata[0][0], 32'h0);
        @(posedge clk); #3 rst_n = 1'b1;

        // m0 write, slave acks two cycles late
        clear_logs();
        s_delay[0] = 2;
        push(0, 0, 1'b1, 32'h0000_1000, 32'hA5A5_0001);
        quiet(0);
        check("wr_acks", ack_who[0].size(), 1);
        check("wr_who", ack_who[0][0], 0);
        check("wr_slv", {slv_log[0][0].grant, slv_log[0][0].we, slv_log[0][0].addr, slv_log[0][0].wdata},
              {2'b01, 1'b1, 32'h0000_1000, 32'hA5A5_0001});
        check("wr_latency", ack_cyc[0][0] - slv_log[0][0].cyc, 3);
        check("wr_rdata", ack_dat[0][0], 32'h1234_4678);

        // m1 read, combinational-style slave
        clear_logs();
        s_delay[0] = 0;
        push(0, 1, 1'b0, 32'h0000_0000, 32'h0);
        quiet(0);
        check("rd_acks", ack_who[0].size(), 1);
        check("rd_who", ack_who[0][0], 1);
        check("rd_data", ack_dat[0][0], 32'h1234_5678);
        check("rd_grant_busy", slv_log[0][0].grant, 2'b10);
        check("rd_latency", ack_cyc[0][0] - slv_log[0][0].cyc, 1);
        check("rd_grant_after", grant[0], 2'b00);
        check("m0_rdata_kept", m_rdata[0][0], 32'h1234_4678);

        // round-robin under continuous contention
        clear_logs();
        s_delay[0] = 1;
        push(0, 0, 1'b0, 32'h10, 32'h0); push(0, 0, 1'b0, 32'h14, 32'h0);
        push(0, 1, 1'b0, 32'h20, 32'h0); push(0, 1, 1'b0, 32'h24, 32'h0);
        quiet(0);
        check_order("rr_order", 0, '{0, 1, 0, 1}, 4);
        if (slv_log[0].size() == 4)
            check("rr_addrs", {slv_log[0][0].addr, slv_log[0][1].addr, slv_log[0][2].addr, slv_log[0][3].addr},
                  {32'h10, 32'h20, 32'h14, 32'h24});
        else
            check("rr_slv_count", slv_log[0].size(), 4);

        // fixed priority: m0 keeps the bus while it requests
        clear_logs();
        s_delay[1] = 1;
        push(1, 0, 1'b1, 32'h100, 32'hA0); push(1, 0, 1'b1, 32'h104, 32'hA1);
        push(1, 0, 1'b1, 32'h108, 32'hA2); push(1, 1, 1'b1, 32'h200, 32'hB0);
        quiet(1);
        check_order("fx_order", 1, '{0, 0, 0, 1}, 4);

        // reset in BUSY: abort immediately, tie after release goes to m0
        s_delay[0] = 0;
        push(0, 0, 1'b0, 32'h30, 32'h0);
        quiet(0);
        clear_logs();
        s_delay[0] = 20;
        push(0, 1, 1'b0, 32'h40, 32'h0);
        for (n = 0; n < 50; n++) begin
            @(posedge clk); #2;
            if (s_enb[0]) break;
        end
        check("rst_busy_reached", (n < 50), 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("rst_async_slv_enb", s_enb[0], 1'b0);
        check("rst_async_grant", grant[0], 2'b00);
        push(0, 0, 1'b0, 32'h50, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_no_ack", ack_who[0].size(), 0);
        s_delay[0] = 0;
        @(posedge clk); #3 rst_n = 1'b1;
        quiet(0);
        check_order("rst_order", 0, '{0, 1, 0, 0}, 2);

`ifdef UDM_ARB_TIMEOUT_EN
        // slave never answers: watchdog completes with DEADBEEF
        clear_logs();
        s_delay[0] = 255;
        push(0, 0, 1'b0, 32'h60, 32'h0);
        quiet(0);
        check("to_who", ack_who[0].size() == 1 && ack_who[0][0] == 0, 1);
        if (ack_dat[0].size() > 0) begin
            check("to_data", ack_dat[0][0], 32'hDEAD_BEEF);
            check("to_latency", ack_cyc[0][0] - slv_log[0][0].cyc, TO_CYC);
        end
        check("to_err_set", err[0], 1'b1);
        clear_logs();
        s_delay[0] = 0;
        push(0, 1, 1'b0, 32'h70, 32'h0);
        quiet(0);
        check("to_err_sticky", err[0], 1'b1);
        check("to_next_data", ack_dat[0].size() == 1 ? ack_dat[0][0] : 32'h0, 32'h1234_5608);
        @(posedge clk); #3 rst_n = 1'b0;
        #2;
        check("to_err_cleared", err[0], 1'b0);
        @(posedge clk); #3 rst_n = 1'b1;
`else
        check("err_tied_low", {err[0], err[1]}, 2'b00);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
